// File: rtl/keypad_pkg.sv
// Shared types, key map and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

    // Scanner FSM states
    typedef enum logic [1:0] {
        StScan    = 2'd0,
        StPressDb = 2'd1,
        StHeld    = 2'd2,
        StRelDb   = 2'd3
    } state_t;

    // Key map indexed [row][col]
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Column drive pattern: only the selected column is pulled low
    function automatic logic [3:0] col_onehot_low(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Index of the lowest row reading low; lowest row wins on ties
    function automatic logic [1:0] lowest_low(input logic [3:0] rs);
        if (!rs[0]) begin
            return 2'd0;
        end else if (!rs[1]) begin
            return 2'd1;
        end else if (!rs[2]) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs.
// Resets to all-ones so no key appears pressed coming out of reset.
module keypad_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_async,
    output logic [3:0] o_sync
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    // Two-stage capture of the row levels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 4'b1111;
            r_sync <= 4'b1111;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a one-cycle
// key_valid strobe per accepted key.
// Optional build macro KEYPAD_REPEAT_EN: while a key stays held, key_valid
// pulses again every REPEAT_CYCLES with the same key_code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 2400,
    parameter int unsigned DEBOUNCE_CYCLES = 48000,
    parameter int unsigned REPEAT_CYCLES   = 1200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int unsigned MaxScanDeb =
        (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned MaxCycles  =
        (MaxScanDeb > REPEAT_CYCLES) ? MaxScanDeb : REPEAT_CYCLES;
    localparam int unsigned CntW       = $clog2(MaxCycles);

    localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_CYCLES - 1);
    localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]      w_rs;
    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_col;
    logic [1:0]      w_col_next;
    logic [1:0]      r_row;
    logic [1:0]      w_row_next;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;
    logic [3:0]      r_key_code;
    logic [3:0]      w_key_code_next;
    logic            r_key_valid;
    logic            w_strobe;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CntW-1:0] RepLast = CntW'(REPEAT_CYCLES - 1);
    logic [CntW-1:0] r_rep;
    logic [CntW-1:0] w_rep_next;
`endif

    keypad_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (rows),
        .o_sync  (w_rs)
    );

    // Next-state, counter and strobe decode
    always_comb begin
        w_state_next    = r_state;
        w_col_next      = r_col;
        w_row_next      = r_row;
        w_cnt_next      = r_cnt + 1'b1;
        w_key_code_next = r_key_code;
        w_strobe        = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        w_rep_next      = r_rep;
`endif
        unique case (r_state)
            StScan: begin
                if (r_cnt == ScanLast) begin
                    w_cnt_next = '0;
                    if (w_rs != 4'b1111) begin
                        w_row_next   = lowest_low(w_rs);
                        w_state_next = StPressDb;
                    end else begin
                        w_col_next = r_col + 2'd1;
                    end
                end
            end
            StPressDb: begin
                if (w_rs[r_row]) begin
                    // Bounce or glitch: give up and move on
                    w_state_next = StScan;
                    w_col_next   = r_col + 2'd1;
                    w_cnt_next   = '0;
                end else if (r_cnt == DebLast) begin
                    w_state_next    = StHeld;
                    w_cnt_next      = '0;
                    w_key_code_next = KEYMAP[r_row][r_col];
                    w_strobe        = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                    w_rep_next      = '0;
`endif
                end
            end
            StHeld: begin
                w_cnt_next = '0;
                if (w_rs[r_row]) begin
                    w_state_next = StRelDb;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (r_rep == RepLast) begin
                        w_rep_next = '0;
                        w_strobe   = 1'b1;
                    end else begin
                        w_rep_next = r_rep + 1'b1;
                    end
`endif
                end
            end
            StRelDb: begin
                if (!w_rs[r_row]) begin
                    // Release bounce: key is still down, no new strobe
                    w_state_next = StHeld;
                    w_cnt_next   = '0;
`ifdef KEYPAD_REPEAT_EN
                    w_rep_next   = '0;
`endif
                end else if (r_cnt == DebLast) begin
                    w_state_next = StScan;
                    w_col_next   = r_col + 2'd1;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = StScan;
                w_cnt_next   = '0;
            end
        endcase
    end

    // FSM, counter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StScan;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_cnt       <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_col       <= w_col_next;
            r_row       <= w_row_next;
            r_cnt       <= w_cnt_next;
            r_key_code  <= w_key_code_next;
            r_key_valid <= w_strobe;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat period counter, only meaningful in StHeld
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rep <= '0;
        end else begin
            r_rep <= w_rep_next;
        end
    end
`endif

    assign cols      = col_onehot_low(r_col);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural keypad matrix.
module tb_keypad_scanner;

    localparam int unsigned ScanCycles = 4;
    localparam int unsigned DebCycles  = 8;
    localparam int unsigned RepCycles  = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;

    logic [3:0] pressed [4];  // pressed[r][c]

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;

    int unsigned strobe_cyc[$];
    logic [3:0]  strobe_code[$];
    int unsigned double_strobes = 0;
    int unsigned bad_cols = 0;
    logic        prev_valid = 1'b0;

    keypad_scanner #(
        .SCAN_CYCLES     (ScanCycles),
        .DEBOUNCE_CYCLES (DebCycles),
        .REPEAT_CYCLES   (RepCycles)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Matrix model: a row reads low when a pressed key sits on a driven column
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) rows[r] = ~(|(pressed[r] & ~cols));
    end

    // Strobe recorder and continuous protocol watch
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (key_valid === 1'b1) begin
                strobe_cyc.push_back(cyc);
                strobe_code.push_back(key_code);
                if (prev_valid === 1'b1) double_strobes++;
            end
            if (!(cols inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad_cols++;
        end
        prev_valid = key_valid;
    end

    // Key legend as printed on the keypad, row-major
    function automatic logic [3:0] ref_code(input int r, input int c);
        string      m;
        logic [7:0] ch;
        m  = "123A456B789CE0FD";
        ch = m[r*4+c];
        if (ch >= 8'd48 && ch <= 8'd57) return 4'(ch - 8'd48);
        return 4'(ch - 8'd55);
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
    endtask

    task automatic wait_cols(input logic [3:0] target, input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            tick(1);
            if (cols === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_strobe(input int unsigned n0, input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            tick(1);
            if (strobe_code.size() > n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols;
        int unsigned n_bad;
        reset = 1'b0;
        release_all();
        #17;
        checks++;
        if (cols !== 4'b1110) begin
            errors++;
            $display("FAIL reset_cols: got %b want 1110", cols);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", key_valid);
        end
        checks++;
        if (key_code !== 4'h0) begin
            errors++;
            $display("FAIL reset_code: got %h want 0", key_code);
        end
        @(negedge clk);
        reset = 1'b1;
        n_bad = 0;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            exp_cols = ~(4'b0001 << ((k / ScanCycles) % 4));
            checks++;
            if (cols !== exp_cols) begin
                errors++;
                $display("FAIL scan_rotate k=%0d: got %b want %b", k, cols, exp_cols);
            end
        end
        checks++;
        if (strobe_code.size() != 0) begin
            errors++;
            $display("FAIL idle_no_strobe: got %0d strobes want 0", strobe_code.size());
        end
        checks++;
        if (key_code !== 4'h0) begin
            errors++;
            $display("FAIL idle_code: got %h want 0", key_code);
        end
    endtask

    task automatic test_clean_press();
        int unsigned n0, t_col, lat, n_moved;
        bit ok, ok2, ok3;
        n0 = strobe_code.size();
        wait_cols(4'b0111, 40, ok);
        wait_cols(4'b1110, 10, ok2);
        pressed[1][1] = 1'b1;
        wait_cols(4'b1101, 10, ok3);
        t_col = cyc;
        checks++;
        if (!(ok && ok2 && ok3)) begin
            errors++;
            $display("FAIL clean_scan_align: got timeout want column sequence");
        end
        wait_strobe(n0, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL clean_strobe: got none want one within 40 clks");
        end else begin
            lat = strobe_cyc[n0] - t_col;
            checks++;
            if (lat < 10 || lat > 14) begin
                errors++;
                $display("FAIL clean_latency: got %0d want 10..14", lat);
            end
            checks++;
            if (strobe_code[n0] !== 4'h5) begin
                errors++;
                $display("FAIL clean_code: got %h want 5", strobe_code[n0]);
            end
        end
        n_moved = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (cols !== 4'b1101) n_moved++;
        end
        checks++;
        if (n_moved != 0) begin
            errors++;
            $display("FAIL clean_col_frozen: got %0d moves want 0", n_moved);
        end
        release_all();
        tick(30);
        checks++;
        if (strobe_code.size() != n0 + 1) begin
            errors++;
            $display("FAIL clean_count: got %0d want %0d", strobe_code.size(), n0 + 1);
        end
    endtask

    task automatic test_press_bounce();
        int unsigned n0, t_solid;
        bit ok;
        n0 = strobe_code.size();
        for (int i = 0; i < 4; i++) begin
            pressed[3][1] = 1'b1;
            tick(3);
            pressed[3][1] = 1'b0;
            tick(3);
        end
        pressed[3][1] = 1'b1;
        t_solid = cyc;
        wait_strobe(n0, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bounce_strobe: got none want one within 60 clks");
        end else begin
            checks++;
            if (strobe_code[n0] !== 4'h0) begin
                errors++;
                $display("FAIL bounce_code: got %h want 0", strobe_code[n0]);
            end
            checks++;
            if (strobe_cyc[n0] < t_solid + DebCycles) begin
                errors++;
                $display("FAIL bounce_timing: got cycle %0d want >= %0d",
                         strobe_cyc[n0], t_solid + DebCycles);
            end
        end
        tick(10);
        release_all();
        tick(30);
        checks++;
        if (strobe_code.size() != n0 + 1) begin
            errors++;
            $display("FAIL bounce_count: got %0d want %0d", strobe_code.size(), n0 + 1);
        end
    endtask

    task automatic test_release_bounce();
        int unsigned n0, t_rel, dt;
        bit ok;
        n0 = strobe_code.size();
        pressed[3][3] = 1'b1;
        wait_strobe(n0, 60, ok);
        checks++;
        if (!ok || strobe_code[n0] !== 4'hD) begin
            errors++;
            $display("FAIL relb_code: got %h want d", ok ? strobe_code[n0] : 4'hx);
        end
        tick(5);
        pressed[3][3] = 1'b0;
        tick(3);
        pressed[3][3] = 1'b1;
        tick(3);
        pressed[3][3] = 1'b0;
        t_rel = cyc;
        checks++;
        if (cols !== 4'b0111) begin
            errors++;
            $display("FAIL relb_held_col: got %b want 0111", cols);
        end
        wait_cols(4'b1110, 30, ok);
        dt = cyc - t_rel;
        checks++;
        if (!ok || dt < DebCycles + 2 || dt > DebCycles + 4) begin
            errors++;
            $display("FAIL relb_resume: got %0d clks (ok=%0d) want %0d..%0d",
                     dt, ok, DebCycles + 2, DebCycles + 4);
        end
        tick(20);
        checks++;
        if (strobe_code.size() != n0 + 1) begin
            errors++;
            $display("FAIL relb_count: got %0d want %0d", strobe_code.size(), n0 + 1);
        end
    endtask

    task automatic test_two_keys();
        int unsigned n0;
        bit ok;
        n0 = strobe_code.size();
        pressed[0][0] = 1'b1;
        pressed[1][0] = 1'b1;
        wait_strobe(n0, 60, ok);
        checks++;
        if (!ok || strobe_code[n0] !== 4'h1) begin
            errors++;
            $display("FAIL two_first: got %h want 1", ok ? strobe_code[n0] : 4'hx);
        end
        tick(10);
        pressed[0][0] = 1'b0;
        wait_strobe(n0 + 1, 80, ok);
        checks++;
        if (!ok || strobe_code[n0+1] !== 4'h4) begin
            errors++;
            $display("FAIL two_second: got %h want 4", ok ? strobe_code[n0+1] : 4'hx);
        end
        tick(10);
        release_all();
        tick(30);
        checks++;
        if (strobe_code.size() != n0 + 2) begin
            errors++;
            $display("FAIL two_count: got %0d want %0d", strobe_code.size(), n0 + 2);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned n0;
        bit ok, ok2, ok3;
        n0 = strobe_code.size();
        wait_cols(4'b0111, 40, ok);
        wait_cols(4'b1110, 10, ok2);
        pressed[1][1] = 1'b1;
        wait_cols(4'b1101, 10, ok3);
        checks++;
        if (!(ok && ok2 && ok3)) begin
            errors++;
            $display("FAIL rmid_align: got timeout want column sequence");
        end
        tick(7);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (cols !== 4'b1110) begin
            errors++;
            $display("FAIL rmid_cols: got %b want 1110", cols);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_valid: got %b want 0", key_valid);
        end
        checks++;
        if (key_code !== 4'h0) begin
            errors++;
            $display("FAIL rmid_code: got %h want 0", key_code);
        end
        tick(3);
        release_all();
        @(negedge clk);
        reset = 1'b1;
        tick(40);
        checks++;
        if (strobe_code.size() != n0) begin
            errors++;
            $display("FAIL rmid_no_strobe: got %0d want %0d", strobe_code.size(), n0);
        end
    endtask

    task automatic test_random();
        int r, c, nb;
        int unsigned n0;
        bit ok;
        for (int it = 0; it < 6; it++) begin
            r  = int'($urandom_range(0, 3));
            c  = int'($urandom_range(0, 3));
            nb = int'($urandom_range(0, 3));
            n0 = strobe_code.size();
            for (int b = 0; b < nb; b++) begin
                pressed[r][c] = 1'b1;
                tick($urandom_range(1, 5));
                pressed[r][c] = 1'b0;
                tick($urandom_range(1, 5));
            end
            pressed[r][c] = 1'b1;
            wait_strobe(n0, 80, ok);
            checks++;
            if (!ok || strobe_code[n0] !== ref_code(r, c)) begin
                errors++;
                $display("FAIL rand_code r=%0d c=%0d: got %h want %h", r, c,
                         ok ? strobe_code[n0] : 4'hx, ref_code(r, c));
            end
            tick($urandom_range(0, 20));
            release_all();
            tick(30);
            checks++;
            if (strobe_code.size() != n0 + 1) begin
                errors++;
                $display("FAIL rand_count r=%0d c=%0d: got %0d want %0d", r, c,
                         strobe_code.size(), n0 + 1);
            end
        end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        int unsigned n0;
        bit ok;
        n0 = strobe_code.size();
        pressed[0][3] = 1'b1;
        wait_strobe(n0, 60, ok);
        tick(80);
        release_all();
        tick(30);
        checks++;
        if (!ok || strobe_code.size() != n0 + 3) begin
            errors++;
            $display("FAIL rep_count: got %0d want %0d", strobe_code.size(), n0 + 3);
        end else begin
            checks++;
            if (strobe_cyc[n0+1] - strobe_cyc[n0] != RepCycles ||
                strobe_cyc[n0+2] - strobe_cyc[n0] != 2 * RepCycles) begin
                errors++;
                $display("FAIL rep_spacing: got +%0d,+%0d want +%0d,+%0d",
                         strobe_cyc[n0+1] - strobe_cyc[n0], strobe_cyc[n0+2] - strobe_cyc[n0],
                         RepCycles, 2 * RepCycles);
            end
            checks++;
            if (strobe_code[n0] !== 4'hA || strobe_code[n0+1] !== 4'hA ||
                strobe_code[n0+2] !== 4'hA) begin
                errors++;
                $display("FAIL rep_code: got %h %h %h want a a a", strobe_code[n0],
                         strobe_code[n0+1], strobe_code[n0+2]);
            end
        end
    endtask
`endif

    task automatic test_protocol();
        checks++;
        if (double_strobes != 0) begin
            errors++;
            $display("FAIL back_to_back_valid: got %0d want 0", double_strobes);
        end
        checks++;
        if (bad_cols != 0) begin
            errors++;
            $display("FAIL cols_onehot: got %0d bad samples want 0", bad_cols);
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_two_keys();
        test_reset_mid();
        test_random();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
